// File: rtl/mem_pkg.sv
// Shared types and constants for the two-requester SRAM arbiter:
// FSM states, strobe levels and grant encoding.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_GPU = 1'b1
  } gnt_t;

  // SRAM control pins are active-low.
  localparam logic STB_ON  = 1'b0;
  localparam logic STB_OFF = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner select for the CPU/GPU arbiter. With MEM_ARBITER_RR_EN defined, ties
// go round-robin (last winner loses); otherwise the CPU always wins ties.
module mem_arb_grant
  import mem_pkg::*;
(
`ifdef MEM_ARBITER_RR_EN
  input  logic clk,
  input  logic rst_n,
  input  logic take,
`endif
  input  logic cpu_req,
  input  logic gpu_req,
  output logic gnt
);

  gnt_t win;

`ifdef MEM_ARBITER_RR_EN
  // prio holds the requester that wins the next tie.
  gnt_t prio;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= GNT_CPU;
    end else if (take) begin
      prio <= (win == GNT_CPU) ? GNT_GPU : GNT_CPU;
    end
  end

  always_comb begin
    win = GNT_CPU;
    if (cpu_req && gpu_req) begin
      win = prio;
    end else if (gpu_req) begin
      win = GNT_GPU;
    end
  end
`else
  always_comb begin
    win = GNT_CPU;
    if (gpu_req && !cpu_req) begin
      win = GNT_GPU;
    end
  end
`endif

  assign gnt = win;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU/GPU) asynchronous SRAM arbiter with a fixed
// SETUP/STROBE/DONE access cycle. Optional macro: MEM_ARBITER_RR_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
)
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_be,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  input  logic        gpu_req,
  input  logic        gpu_we,
  input  logic [15:0] gpu_addr,
  input  logic [15:0] gpu_wdata,
  input  logic [1:0]  gpu_be,
  output logic        gpu_ack,
  output logic [15:0] gpu_rdata,
  output logic        CE,
  output logic        OE,
  output logic        WR,
  output logic        UB,
  output logic        LB,
  output logic [15:0] ADDR,
  output logic [15:0] DOUT,
  output logic        DOE,
  input  logic [15:0] DIN
);

  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  gnt_t        gnt_q;
  logic        gnt_sel;
  logic        we_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic [3:0]  cnt_q;
  logic        start;
  logic        last_strobe;

  assign start       = (state_q == IDLE) && (cpu_req || gpu_req);
  assign last_strobe = (state_q == STROBE) && (cnt_q == CNT_LAST);

  mem_arb_grant u_grant (
`ifdef MEM_ARBITER_RR_EN
    .clk     (CLK),
    .rst_n   (RST_N),
    .take    (start),
`endif
    .cpu_req (cpu_req),
    .gpu_req (gpu_req),
    .gnt     (gnt_sel)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request fields are captured once at grant; later changes are ignored.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gnt_q   <= GNT_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (start) begin
        gnt_q <= gnt_t'(gnt_sel);
        if (gnt_t'(gnt_sel) == GNT_GPU) begin
          we_q    <= gpu_we;
          addr_q  <= gpu_addr;
          wdata_q <= gpu_wdata;
          be_q    <= gpu_be;
        end else begin
          we_q    <= cpu_we;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
          be_q    <= cpu_be;
        end
      end
      if (state_q == SETUP) begin
        cnt_q <= '0;
      end else if (state_q == STROBE) begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cpu_rdata <= '0;
      gpu_rdata <= '0;
    end else if (last_strobe && !we_q) begin
      if (gnt_q == GNT_GPU) begin
        gpu_rdata <= DIN;
      end else begin
        cpu_rdata <= DIN;
      end
    end
  end

  // Strobes decode straight from the state register so reset releases them
  // asynchronously.
  always_comb begin
    state_d = state_q;
    CE      = STB_OFF;
    OE      = STB_OFF;
    WR      = STB_OFF;
    UB      = STB_OFF;
    LB      = STB_OFF;
    DOE     = 1'b0;
    cpu_ack = 1'b0;
    gpu_ack = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || gpu_req) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        CE      = STB_ON;
        UB      = ~be_q[1];
        LB      = ~be_q[0];
        DOE     = we_q;
        state_d = STROBE;
      end
      STROBE: begin
        CE  = STB_ON;
        UB  = ~be_q[1];
        LB  = ~be_q[0];
        DOE = we_q;
        if (we_q) begin
          WR = STB_ON;
        end else begin
          OE = STB_ON;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        CE      = STB_ON;
        UB      = ~be_q[1];
        LB      = ~be_q[0];
        DOE     = we_q;
        cpu_ack = (gnt_q == GNT_CPU);
        gpu_ack = (gnt_q == GNT_GPU);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ADDR = addr_q;
  assign DOUT = wdata_q;

endmodule
